// File: rtl/cfg_pkg.sv
// ---------------------------------------------------------------------------
// cfg_pkg
// Shared definitions for the configuration stream loader: default geometry
// of the fabric configuration chain, the loader FSM state encoding and the
// words-per-column computation.
// No ports (package).
// ---------------------------------------------------------------------------
package cfg_pkg;

  localparam int CFG_HEIGHT_DEF = 40;  // column width in bits
  localparam int CFG_COLS_DEF   = 16;  // columns per bitstream
  localparam int WORD_W_DEF     = 32;  // input word width

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Words needed to cover one column: ceil(height / word_w).
  function automatic int calc_wpc(input int height, input int word_w);
    return (height + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/cfg_col_packer.sv
// ---------------------------------------------------------------------------
// cfg_col_packer
// Collects WPC input words into one CFG_HEIGHT-bit column. Word slot k lands
// at bits [k*WORD_W +: WORD_W]; bits past CFG_HEIGHT are dropped.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   clear     restart the slot counter (new column / new load)
//   wr        store wdata into the current slot
//   wdata     configuration word
//   col_full  high when the word being written completes the column
//   col_data  packed column contents
// ---------------------------------------------------------------------------
module cfg_col_packer
  import cfg_pkg::*;
#(
  parameter int CFG_HEIGHT = CFG_HEIGHT_DEF,
  parameter int WORD_W     = WORD_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  wr,
  input  logic [WORD_W-1:0]     wdata,
  output logic                  col_full,
  output logic [CFG_HEIGHT-1:0] col_data
);

  localparam int WPC   = calc_wpc(CFG_HEIGHT, WORD_W);
  localparam int CNT_W = $clog2(WPC) + 1;

  logic [CNT_W-1:0]      word_cnt;
  logic [CFG_HEIGHT-1:0] col_q;

  // NOTE: the column buffer is a plain register, not a RAM, so it takes the
  // async reset like any other flop and cdata starts from a known zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt <= '0;
      col_q    <= '0;
    end else if (clear) begin
      word_cnt <= '0;
    end else if (wr) begin
      word_cnt <= word_cnt + CNT_W'(1);
      // Only the bits that fall inside the column are stored.
      for (int b = 0; b < CFG_HEIGHT; b++) begin
        if (word_cnt == CNT_W'(b / WORD_W)) col_q[b] <= wdata[b % WORD_W];
      end
    end
  end

  assign col_full = wr && (word_cnt == CNT_W'(WPC - 1));
  assign col_data = col_q;

endmodule

// File: rtl/cfg_stream_loader.sv
// ---------------------------------------------------------------------------
// cfg_stream_loader
// Feeds the fabric configuration chain from a valid/ready word stream. Words
// are packed into columns, each column is presented on cdata with a one-cycle
// shift strobe, and the fabric is held in reset until the full bitstream of
// CFG_COLS columns has been shifted in.
// Build option: define CFG_LOADER_CHECK_EN to require one trailing checksum
// word (XOR of all configuration words); a mismatch raises err and keeps the
// fabric in reset.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   start       one-cycle pulse starting a load (ignored while busy)
//   in_valid    / in_data / in_ready   input word stream
//   shift       chain shift strobe, one cycle per column
//   cdata       column data, valid while shift=1, holds otherwise
//   fabric_rst  fabric reset, released only after a complete good load
//   busy        load in progress
//   done        bitstream loaded (level, until next start)
//   err         checksum mismatch (always 0 without CFG_LOADER_CHECK_EN)
// ---------------------------------------------------------------------------
module cfg_stream_loader
  import cfg_pkg::*;
#(
  parameter int CFG_HEIGHT = CFG_HEIGHT_DEF,
  parameter int CFG_COLS   = CFG_COLS_DEF,
  parameter int WORD_W     = WORD_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [WORD_W-1:0]     in_data,
  output logic                  in_ready,
  output logic                  shift,
  output logic [CFG_HEIGHT-1:0] cdata,
  output logic                  fabric_rst,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int COL_W = $clog2(CFG_COLS) + 1;

  state_t                state, state_nxt;
  logic [COL_W-1:0]      col_cnt;
  logic [CFG_HEIGHT-1:0] cdata_q;
  logic [CFG_HEIGHT-1:0] col_data;
  logic                  col_full;
  logic                  launch;
  logic                  word_wr;
  logic                  last_col;
  logic                  err_q;

  // A start is honoured only when no load is running.
  assign launch   = start && (state == ST_IDLE || state == ST_DONE);
  assign word_wr  = in_valid && in_ready && (state == ST_FILL);
  assign last_col = (col_cnt == COL_W'(CFG_COLS - 1));

  cfg_col_packer #(
    .CFG_HEIGHT (CFG_HEIGHT),
    .WORD_W     (WORD_W)
  ) u_packer (
    .clk      (clk),
    .rst      (rst),
    .clear    (launch || (state == ST_SHIFT)),
    .wr       (word_wr),
    .wdata    (in_data),
    .col_full (col_full),
    .col_data (col_data)
  );

  // NOTE: state-holding flops use non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    shift     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (launch) state_nxt = ST_FILL;
      end
      ST_FILL: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (col_full) state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        shift = 1'b1;
        busy  = 1'b1;
        if (last_col) begin
`ifdef CFG_LOADER_CHECK_EN
          state_nxt = ST_CHECK;
`else
          state_nxt = ST_DONE;
`endif
        end else begin
          state_nxt = ST_FILL;
        end
      end
`ifdef CFG_LOADER_CHECK_EN
      ST_CHECK: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) state_nxt = ST_DONE;
      end
`endif
      ST_DONE: begin
        done = 1'b1;
        if (launch) state_nxt = ST_FILL;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_cnt <= '0;
      cdata_q <= '0;
    end else if (launch) begin
      col_cnt <= '0;
    end else if (state == ST_SHIFT) begin
      col_cnt <= col_cnt + COL_W'(1);
      cdata_q <= col_data;
    end
  end

  // The live column is shown during SHIFT; afterwards the captured copy holds.
  assign cdata = (state == ST_SHIFT) ? col_data : cdata_q;

`ifdef CFG_LOADER_CHECK_EN
  logic [WORD_W-1:0] chk_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk_q <= '0;
      err_q <= 1'b0;
    end else if (launch) begin
      chk_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (word_wr) chk_q <= chk_q ^ in_data;
      if (state == ST_CHECK && in_valid) err_q <= (in_data != chk_q);
    end
  end
`else
  assign err_q = 1'b0;
`endif

  assign err        = err_q;
  // The fabric leaves reset only in DONE after a clean load.
  assign fabric_rst = !(state == ST_DONE && !err_q);

endmodule

// File: tb/tb_cfg_stream_loader.sv
// ---------------------------------------------------------------------------
// tb_cfg_stream_loader
// Scoreboard bench: the driver pushes expected columns and expected end-of-load
// status into queues, an independent monitor pops and compares them whenever
// the loader strobes shift or raises done.
// Geometry: CFG_HEIGHT=40, WORD_W=32, CFG_COLS=4 (two words per column).
// ---------------------------------------------------------------------------
module tb_cfg_stream_loader;

  localparam int H    = 40;
  localparam int W    = 32;
  localparam int COLS = 4;
  localparam int WPC  = (H + W - 1) / W;
  localparam int NW   = COLS * WPC;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         shift;
  logic [H-1:0] cdata;
  logic         fabric_rst;
  logic         busy;
  logic         done;
  logic         err;

  cfg_stream_loader #(
    .CFG_HEIGHT (H),
    .CFG_COLS   (COLS),
    .WORD_W     (W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .shift      (shift),
    .cdata      (cdata),
    .fabric_rst (fabric_rst),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic err;
    logic frst;
  } end_t;

  logic [H-1:0] col_q[$];
  end_t         end_q[$];
  logic [W-1:0] cfg_words [NW];

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [H-1:0] last_cdata = '0;
  int           cyc = 0;
  int           last_shift_cyc = 0;
  logic         done_d = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference column: words of column c laid side by side, word 0 lowest,
  // then cut to the column height.
  function automatic logic [H-1:0] model_col(input int c);
    logic [WPC*W-1:0] wide = '0;
    for (int k = 0; k < WPC; k++)
      wide = wide | ((WPC*W)'(cfg_words[c*WPC + k]) << (k*W));
    return wide[H-1:0];
  endfunction

  function automatic logic [W-1:0] model_xor();
    logic [W-1:0] x = '0;
    for (int i = 0; i < NW; i++) x = x ^ cfg_words[i];
    return x;
  endfunction

  // Monitor
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (shift) begin
        if (col_q.size() == 0) begin
          check("unexpected_shift", 64'(shift), 64'd0);
        end else begin
          check("shift_cdata", 64'(cdata), 64'(col_q.pop_front()));
        end
        last_cdata = cdata;
        last_shift_cyc = cyc;
      end else begin
        check("cdata_hold", 64'(cdata), 64'(last_cdata));
      end
      if (busy) check("fabric_rst_while_busy", 64'(fabric_rst), 64'd1);
      if (done && !done_d) begin
        check("missing_shifts", 64'(col_q.size()), 64'd0);
        if (end_q.size() == 0) begin
          check("unexpected_done", 64'(done), 64'd0);
        end else begin
          end_t e;
          e = end_q.pop_front();
          check("end_err", 64'(err), 64'(e.err));
          check("end_fabric_rst", 64'(fabric_rst), 64'(e.frst));
          check("end_busy", 64'(busy), 64'd0);
        end
`ifndef CFG_LOADER_CHECK_EN
        check("done_latency", 64'(cyc - last_shift_cyc), 64'd1);
`endif
      end
      done_d = done;
    end
  end

  // vmode: 0 always valid, 1 random valid, 2 valid pattern 1,0,0,1
  task automatic run_load(input int vmode, input bit start_busy, input bit bad_sum,
                          input int abort_at);
    int   pat[4] = '{1, 0, 0, 1};
    int   n_total;
    int   idx;
    int   cnt;
    logic v;
    end_t e;
    logic [W-1:0] sum;

    sum = model_xor() ^ W'(bad_sum);
    for (int c = 0; c < COLS; c++) col_q.push_back(model_col(c));
`ifdef CFG_LOADER_CHECK_EN
    n_total = NW + 1;
    e.err   = bad_sum;
    e.frst  = bad_sum;
`else
    n_total = NW;
    e.err   = 1'b0;
    e.frst  = 1'b0;
`endif
    end_q.push_back(e);

    // Start together with a valid word: the word must not be taken.
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = cfg_words[0];
    @(negedge clk);
    check("ready_low_on_start", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    start = 1'b0;

    idx = 0;
    cnt = 0;
    while (idx < n_total && cnt < 2000) begin
      if (abort_at > 0 && idx == abort_at) break;
      case (vmode)
        0:       v = 1'b1;
        1:       v = ($urandom_range(0, 3) != 0);
        default: v = pat[cnt % 4] != 0;
      endcase
      in_valid = v;
      if (!v)            in_data = $urandom;
      else if (idx < NW) in_data = cfg_words[idx];
      else               in_data = sum;
      start = start_busy && ($urandom_range(0, 2) == 0);
      @(negedge clk);
      if (v && in_ready) idx++;
      @(posedge clk); #1;
      cnt++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    if (cnt >= 2000) check("feed_timeout", 64'(idx), 64'(n_total));

    if (abort_at > 0) begin
      // One cycle lets the pending shift go out, then reset mid-load.
      @(posedge clk); #1;
      rst = 1'b1;
      col_q.delete();
      end_q.delete();
      last_cdata = '0;
      done_d = 1'b0;
      #1;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_fabric_rst", 64'(fabric_rst), 64'd1);
      check("abort_done", 64'(done), 64'd0);
      check("abort_shift", 64'(shift), 64'd0);
      check("abort_cdata", 64'(cdata), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      return;
    end

    cnt = 0;
    while (!done && cnt < 50) begin
      @(posedge clk); #1;
      cnt++;
    end
    if (cnt >= 50) check("done_timeout", 64'(done), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    check("done_level", 64'(done), 64'd1);
    check("done_fabric_rst", 64'(fabric_rst), 64'(e.frst));
  endtask

  task automatic rand_words();
    for (int i = 0; i < NW; i++) cfg_words[i] = $urandom;
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_shift", 64'(shift), 64'd0);
    check("rst_cdata", 64'(cdata), 64'd0);
    check("rst_fabric_rst", 64'(fabric_rst), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic load: column 0 = {32'h00000055, 32'hffff0000}.
    rand_words();
    cfg_words[0] = 32'hffff0000;
    cfg_words[1] = 32'h00000055;
    run_load(0, 1'b0, 1'b0, 0);

    // Truncation: upper bits of the high word are dropped.
    rand_words();
    cfg_words[1] = 32'hABCDEF12;
    run_load(0, 1'b0, 1'b0, 0);

    // Stall pattern inside every column.
    rand_words();
    run_load(2, 1'b0, 1'b0, 0);

    // Reset after the second column's shift, then a clean full load.
    rand_words();
    run_load(0, 1'b0, 1'b0, 4);
    rand_words();
    run_load(0, 1'b0, 1'b0, 0);

    // start pulses while busy.
    rand_words();
    run_load(1, 1'b1, 1'b0, 0);

    // Checksum good then bad (bad_sum only matters in the checksum build).
    rand_words();
    run_load(0, 1'b0, 1'b0, 0);
    rand_words();
    run_load(1, 1'b0, 1'b1, 0);

    // Randomized loads.
    for (int t = 0; t < 6; t++) begin
      rand_words();
      run_load(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 0);
    end

    repeat (3) @(posedge clk);
    #1;
    check("final_col_queue_empty", 64'(col_q.size()), 64'd0);
    check("final_end_queue_empty", 64'(end_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
